seq_ctrl: RTL and testbench

Fetch/execute sequencer and program-counter owner for the 16-bit accumulator CPU. It issues instruction fetches over a request/acknowledge handshake and latches each fetched word into the instruction register. It then gives the datapath one execute-enable pulse per instruction, and computes the next PC from the decoded jump/call/ret controls, the flags and a hardware return stack. It sits between instruction memory, the instruction decoder and the datapath register/flag enables.

---
 rtl/seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// seq_ctrl: fetch/execute sequencer and program-counter owner for the
// 16-bit accumulator CPU. It fetches one word per instruction over a req/ack
// handshake and gives the datapath one commit strobe per instruction. It
// computes the next PC from jump/call/ret controls, the flags and a hardware
// return stack.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   imem_req/addr/ack  instruction fetch handshake (addr == pc)
//   ir_load            latch instruction register (req & ack)
//   exec_en            one-cycle commit strobe for datapath enables
//   stall              datapath not ready to commit
//   is_jump, call, ret, jump_cond, target
//                      decoded controls of the instruction in IR
//   zero, carry        registered accumulator flags
//   pc                 current program counter
//   halt               sticky fault halt
//   rs_err             [0] return-stack overflow, [1] underflow (sticky)
module seq_ctrl #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned RS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            ir_load,
    output logic            exec_en,
    input  logic            stall,
    input  logic            is_jump,
    input  logic            call,
    input  logic            ret,
    input  logic [1:0]      jump_cond,
    input  logic [PC_W-1:0] target,
    input  logic            zero,
    input  logic            carry,
    output logic [PC_W-1:0] pc,
    output logic            halt,
    output logic [1:0]      rs_err
);

    localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(RS_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        rs_err_q, rs_err_d;
    logic [PC_W-1:0]   rs_q [RS_DEPTH];

    logic              push;
    logic              taken;
    logic [PC_W-1:0]   pc_inc;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;

    assign pc_inc   = pc_q + PC_W'(1);
    assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
    assign push_idx = IDX_W'(cnt_q);

    // Branch condition, evaluated on the flags present in the commit cycle
    always_comb begin
        taken = 1'b0;
        case (jump_cond)
            2'b00:   taken = 1'b1;
            2'b01:   taken = zero;
            2'b10:   taken = ~zero;
            default: taken = carry;
        endcase
    end

    // Next-state, next-pc and handshake strobes
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        rs_err_d = rs_err_q;
        push     = 1'b0;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        exec_en  = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    // A fault still commits datapath effects; only pc/stack hold
                    exec_en = 1'b1;
                    state_d = S_FETCH;
                    if (ret) begin
                        if (cnt_q == CNT_W'(0)) begin
                            rs_err_d[1] = 1'b1;
                            state_d     = S_HALT;
                        end else begin
                            pc_d  = rs_q[top_idx];
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else if (call) begin
                        if (cnt_q == CNT_W'(RS_DEPTH)) begin
                            rs_err_d[0] = 1'b1;
                            state_d     = S_HALT;
                        end else begin
                            push  = 1'b1;
                            pc_d  = target;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (is_jump && taken) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Control state; stack contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            cnt_q    <= '0;
            rs_err_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            rs_err_q <= rs_err_d;
        end
    end

    // Return-stack storage; a reset cycle suppresses any pending push
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            rs_q[push_idx] <= pc_inc;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halt      = (state_q == S_HALT);
    assign rs_err    = rs_err_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl. Inputs change on the falling
// edge; outputs are checked 2 time units later, well before the rising edge.
module tb_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [9:0] imem_addr;
    logic       imem_ack;
    logic       ir_load;
    logic       exec_en;
    logic       stall;
    logic       is_jump;
    logic       call;
    logic       ret;
    logic [1:0] jump_cond;
    logic [9:0] target;
    logic       zero;
    logic       carry;
    logic [9:0] pc;
    logic       halt;
    logic [1:0] rs_err;

    int total = 0;
    int bad   = 0;
    logic ex;

    always #5 clk = ~clk;

    seq_ctrl #(.PC_W(10), .RS_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .ir_load   (ir_load),
        .exec_en   (exec_en),
        .stall     (stall),
        .is_jump   (is_jump),
        .call      (call),
        .ret       (ret),
        .jump_cond (jump_cond),
        .target    (target),
        .zero      (zero),
        .carry     (carry),
        .pc        (pc),
        .halt      (halt),
        .rs_err    (rs_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction: FETCH with immediate ack, then EXEC with the given
    // controls and no stall. Entered and left at falling edge + 2.
    task automatic do_instr(input logic ij, input logic cl, input logic rt,
                            input logic [1:0] cond, input logic [9:0] tgt,
                            input logic z, input logic c, output logic ex_o);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        is_jump   = ij;
        call      = cl;
        ret       = rt;
        jump_cond = cond;
        target    = tgt;
        zero      = z;
        carry     = c;
        #2;
        ex_o = exec_en;
        @(negedge clk);
        is_jump   = 1'b0;
        call      = 1'b0;
        ret       = 1'b0;
        jump_cond = 2'b00;
        target    = '0;
        zero      = 1'b0;
        carry     = 1'b0;
        #2;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; is_jump = 1'b0;
        call = 1'b0; ret = 1'b0; jump_cond = 2'b00; target = '0;
        zero = 1'b0; carry = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        #2;
        chk("rst_pc",     32'(pc), 32'h0);
        chk("rst_halt",   32'(halt), 32'h0);
        chk("rst_rs_err", 32'(rs_err), 32'h0);
        chk("rst_req",    32'(imem_req), 32'h1);
        chk("rst_addr",   32'(imem_addr), 32'h0);

        // Sequential execution with ack tied high: two cycles per instruction
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc",      32'(pc), 32'(i));
            chk("seq_ir_load", 32'(ir_load), 32'h1);
            chk("seq_exec_lo", 32'(exec_en), 32'h0);
            @(negedge clk); #2;
            chk("seq_exec_hi", 32'(exec_en), 32'h1);
            chk("seq_req_lo",  32'(imem_req), 32'h0);
            @(negedge clk); #2;
        end
        @(negedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        #2;

        // Ack delayed 3 cycles at pc=5: address held 4 cycles, one ir_load
        for (int k = 0; k < 3; k++) begin
            chk("wait_addr",    32'(imem_addr), 32'h5);
            chk("wait_req",     32'(imem_req), 32'h1);
            chk("wait_ir_load", 32'(ir_load), 32'h0);
            @(negedge clk);
            if (k == 2) imem_ack = 1'b1;
            #2;
        end
        chk("ack_addr",    32'(imem_addr), 32'h5);
        chk("ack_ir_load", 32'(ir_load), 32'h1);
        @(negedge clk);
        imem_ack = 1'b0;
        #2;
        chk("ack_exec",    32'(exec_en), 32'h1);
        chk("ack_no_load", 32'(ir_load), 32'h0);
        @(negedge clk); #2;
        chk("ack_next_pc", 32'(pc), 32'h6);

        // Conditional jumps and PC wrap
        do_instr(1'b1, 1'b0, 1'b0, 2'b00, 10'h010, 1'b0, 1'b0, ex);
        chk("jmp_pc", 32'(pc), 32'h010);
        do_instr(1'b1, 1'b0, 1'b0, 2'b01, 10'h3F0, 1'b1, 1'b0, ex);
        chk("jz_taken", 32'(pc), 32'h3F0);
        do_instr(1'b1, 1'b0, 1'b0, 2'b00, 10'h010, 1'b0, 1'b0, ex);
        do_instr(1'b1, 1'b0, 1'b0, 2'b01, 10'h3F0, 1'b0, 1'b0, ex);
        chk("jz_not_taken", 32'(pc), 32'h011);
        do_instr(1'b1, 1'b0, 1'b0, 2'b10, 10'h2AA, 1'b0, 1'b0, ex);
        chk("jnz_taken", 32'(pc), 32'h2AA);
        do_instr(1'b1, 1'b0, 1'b0, 2'b00, 10'h3FF, 1'b0, 1'b0, ex);
        do_instr(1'b1, 1'b0, 1'b0, 2'b11, 10'h123, 1'b0, 1'b0, ex);
        chk("jc_wrap", 32'(pc), 32'h000);
        do_instr(1'b1, 1'b0, 1'b0, 2'b11, 10'h123, 1'b0, 1'b1, ex);
        chk("jc_taken", 32'(pc), 32'h123);

        // Nested call / return
        do_instr(1'b1, 1'b0, 1'b0, 2'b00, 10'h020, 1'b0, 1'b0, ex);
        do_instr(1'b0, 1'b1, 1'b0, 2'b10, 10'h100, 1'b1, 1'b0, ex);
        chk("call1", 32'(pc), 32'h100);
        do_instr(1'b0, 1'b1, 1'b0, 2'b00, 10'h200, 1'b0, 1'b0, ex);
        chk("call2", 32'(pc), 32'h200);
        do_instr(1'b0, 1'b0, 1'b1, 2'b00, 10'h000, 1'b0, 1'b0, ex);
        chk("ret1", 32'(pc), 32'h101);
        do_instr(1'b0, 1'b0, 1'b1, 2'b00, 10'h000, 1'b0, 1'b0, ex);
        chk("ret2", 32'(pc), 32'h021);

        // Return address pushed from 0x3FF wraps to 0
        do_instr(1'b1, 1'b0, 1'b0, 2'b00, 10'h3FF, 1'b0, 1'b0, ex);
        do_instr(1'b0, 1'b1, 1'b0, 2'b00, 10'h050, 1'b0, 1'b0, ex);
        chk("call_wrap", 32'(pc), 32'h050);
        do_instr(1'b0, 1'b0, 1'b1, 2'b00, 10'h000, 1'b0, 1'b0, ex);
        chk("ret_wrap", 32'(pc), 32'h000);
        do_instr(1'b1, 1'b0, 1'b0, 2'b00, 10'h021, 1'b0, 1'b0, ex);

        // Stall 4 cycles on a taken JMP
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; is_jump = 1'b1; target = 10'h055; stall = 1'b1;
        #2;
        for (int k = 0; k < 4; k++) begin
            chk("stall_exec", 32'(exec_en), 32'h0);
            chk("stall_pc",   32'(pc), 32'h021);
            @(negedge clk);
            if (k == 3) stall = 1'b0;
            #2;
        end
        chk("stall_commit", 32'(exec_en), 32'h1);
        @(negedge clk);
        is_jump = 1'b0; target = '0;
        #2;
        chk("stall_pc_after", 32'(pc), 32'h055);

        // Reset during a stalled jump aborts it
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; is_jump = 1'b1; target = 10'h0AA; stall = 1'b1;
        #2;
        chk("abort_exec", 32'(exec_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; is_jump = 1'b0; target = '0; stall = 1'b0;
        #2;
        chk("abort_pc",  32'(pc), 32'h0);
        chk("abort_req", 32'(imem_req), 32'h1);

        // Eight calls fill the stack, the ninth overflows
        for (int k = 0; k < 8; k++)
            do_instr(1'b0, 1'b1, 1'b0, 2'b00, 10'h040, 1'b0, 1'b0, ex);
        chk("fill_pc",   32'(pc), 32'h040);
        chk("fill_halt", 32'(halt), 32'h0);
        chk("fill_err",  32'(rs_err), 32'h0);
        do_instr(1'b0, 1'b1, 1'b0, 2'b00, 10'h300, 1'b0, 1'b0, ex);
        chk("ovf_exec", 32'(ex), 32'h1);
        chk("ovf_halt", 32'(halt), 32'h1);
        chk("ovf_err",  32'(rs_err), 32'h1);
        chk("ovf_pc",   32'(pc), 32'h040);
        chk("ovf_req",  32'(imem_req), 32'h0);
        imem_ack = 1'b1;
        @(negedge clk); #2;
        chk("halt_req",  32'(imem_req), 32'h0);
        chk("halt_load", 32'(ir_load), 32'h0);
        chk("halt_exec", 32'(exec_en), 32'h0);
        chk("halt_stay", 32'(halt), 32'h1);
        imem_ack = 1'b0;

        // Return with an empty stack after reset underflows
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rst2_halt", 32'(halt), 32'h0);
        chk("rst2_err",  32'(rs_err), 32'h0);
        do_instr(1'b0, 1'b0, 1'b1, 2'b00, 10'h000, 1'b0, 1'b0, ex);
        chk("unf_exec", 32'(ex), 32'h1);
        chk("unf_halt", 32'(halt), 32'h1);
        chk("unf_err",  32'(rs_err), 32'h2);
        chk("unf_pc",   32'(pc), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
